// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: opcodes, exec/idle levels,
// FSM encodings and instruction field helpers.
package pipe_ctrl_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_LOAD  = 5'd5;
  localparam logic [4:0] OP_STORE = 5'd6;
  localparam logic [4:0] OP_BZ    = 5'd7;
  localparam logic [4:0] OP_JUMP  = 5'd8;
  localparam logic [4:0] OP_HALT  = 5'd31;

  localparam logic ST_EXEC = 1'b1;
  localparam logic ST_IDLE = 1'b0;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'd0,
    FSM_RUN    = 2'd1,
    FSM_STEP   = 2'd2,
    FSM_HALTED = 2'd3
  } fsm_state_t;

  // Instruction layout: [15:11] opcode, [10:8] rd, [6:4] rs1, [2:0] rs2.
  function automatic logic [4:0] opcode(input logic [15:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [2:0] rd(input logic [15:0] ir);
    return ir[10:8];
  endfunction

  function automatic logic [2:0] rs1(input logic [15:0] ir);
    return ir[6:4];
  endfunction

  function automatic logic [2:0] rs2(input logic [15:0] ir);
    return ir[2:0];
  endfunction

  // Opcodes whose source register fields are real reads and can hit a load-use hazard.
  function automatic logic is_reg_src(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_STORE) || (op == OP_BZ);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Combinational load-use stall and taken-branch flush detection.
module hazard_unit
  import pipe_ctrl_pkg::*;
(
  input  logic        exec,
  input  logic [15:0] id_ir,
  input  logic [15:0] ex_ir,
  input  logic        branch_taken,
  output logic        stall,
  output logic        flush
);

  logic load_use;

  always_comb begin
    load_use = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    if (opcode(ex_ir) == OP_LOAD && is_reg_src(opcode(id_ir)) &&
        (rd(ex_ir) == rs1(id_ir) || rd(ex_ir) == rs2(id_ir)))
      load_use = 1'b1;
    // Flush squashes the dependent instruction anyway, so it overrides stall.
    if (exec) begin
      flush = branch_taken;
      stall = load_use && !branch_taken;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline run-control FSM (idle/run/step/halted), exec-cycle counter,
// and hazard unit instance.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic [15:0] id_ir,
  input  logic [15:0] ex_ir,
  input  logic [15:0] wb_ir,
  input  logic        branch_taken,
  output logic        state,
  output logic        stall,
  output logic        flush,
  output logic        halted,
  output logic [15:0] cycle_cnt
);

  fsm_state_t fsm_q, fsm_d;
  logic       clear_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fsm_q <= FSM_IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d     = fsm_q;
    clear_cnt = 1'b0;
    case (fsm_q)
      FSM_IDLE: begin
        if (start) begin
          fsm_d     = FSM_RUN;
          clear_cnt = 1'b1;
        end else if (step) begin
          fsm_d = FSM_STEP;
        end
      end
      FSM_STEP: fsm_d = FSM_IDLE;
      FSM_RUN: begin
        if (opcode(wb_ir) == OP_HALT) fsm_d = FSM_HALTED;
        else if (stop)                fsm_d = FSM_IDLE;
      end
      FSM_HALTED: begin
        if (start) begin
          fsm_d     = FSM_RUN;
          clear_cnt = 1'b1;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  assign state  = (fsm_q == FSM_RUN || fsm_q == FSM_STEP) ? ST_EXEC : ST_IDLE;
  assign halted = (fsm_q == FSM_HALTED);

  // Clearing only happens from idle-level states, so it never competes with counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cycle_cnt <= 16'd0;
    else if (clear_cnt)
      cycle_cnt <= 16'd0;
    else if (state == ST_EXEC && cycle_cnt != CNT_MAX)
      cycle_cnt <= cycle_cnt + 16'd1;
  end

  hazard_unit u_hazard (
    .exec         (state == ST_EXEC),
    .id_ir        (id_ir),
    .ex_ir        (ex_ir),
    .branch_taken (branch_taken),
    .stall        (stall),
    .flush        (flush)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl: run/step/halt control, hazards, counter saturation, reset.
module tb_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        step  = 1'b0;
  logic [15:0] id_ir = 16'h0;
  logic [15:0] ex_ir = 16'h0;
  logic [15:0] wb_ir = 16'h0;
  logic        branch_taken = 1'b0;
  logic        state, stall, flush, halted;
  logic [15:0] cycle_cnt;

  int total = 0;
  int bad   = 0;

  // LOAD r3 ; ADD rd=1 rs1=r3 rs2=r2 ; ADD rs1=r2 rs2=r1 ; ADD rs1=r1 rs2=r3 ; JUMP with r3 bits ; ADD rd=r3 ; HALT
  localparam logic [15:0] LOAD_R3   = 16'h2B00;
  localparam logic [15:0] ADD_RS1_3 = 16'h0932;
  localparam logic [15:0] ADD_R2_R1 = 16'h0921;
  localparam logic [15:0] ADD_RS2_3 = 16'h0913;
  localparam logic [15:0] JUMP_33   = 16'h4033;
  localparam logic [15:0] ADD_RD3   = 16'h0B00;
  localparam logic [15:0] HALT_IR   = 16'hF800;

  pipe_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .step         (step),
    .id_ir        (id_ir),
    .ex_ir        (ex_ir),
    .wb_ir        (wb_ir),
    .branch_taken (branch_taken),
    .state        (state),
    .stall        (stall),
    .flush        (flush),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    chk1("reset_state", state, 1'b0);
    chk1("reset_halted", halted, 1'b0);
    chk16("reset_cnt", cycle_cnt, 16'h0);
    chk1("reset_stall", stall, 1'b0);
    chk1("reset_flush", flush, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk1("idle_after_release", state, 1'b0);
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("start_state", state, 1'b1);
    chk16("start_cnt0", cycle_cnt, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk16($sformatf("run_cnt%0d", i), cycle_cnt, 16'(i));
    end
    start = 1'b1;
    step  = 1'b1;
    tick();
    start = 1'b0;
    step  = 1'b0;
    chk1("run_ignores_start", state, 1'b1);
    chk16("run_no_clear", cycle_cnt, 16'd4);
  endtask

  task automatic test_step();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk1("stop_state", state, 1'b0);
    chk16("stop_cnt", cycle_cnt, 16'd5);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk1("step_state_exec", state, 1'b1);
    chk16("step_no_clear", cycle_cnt, 16'd5);
    tick();
    chk1("step_state_idle", state, 1'b0);
    chk16("step_cnt_inc", cycle_cnt, 16'd6);
    tick();
    chk1("step_stays_idle", state, 1'b0);
  endtask

  task automatic test_stall();
    ex_ir = LOAD_R3;
    id_ir = ADD_RS1_3;
    #1;
    chk1("idle_no_stall", stall, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("stall_rs1", stall, 1'b1);
    chk1("stall_rs1_noflush", flush, 1'b0);
    id_ir = ADD_R2_R1;
    #1;
    chk1("nostall_r2", stall, 1'b0);
    id_ir = ADD_RS2_3;
    #1;
    chk1("stall_rs2", stall, 1'b1);
    id_ir = JUMP_33;
    #1;
    chk1("nostall_nonreg", stall, 1'b0);
    id_ir = ADD_RS1_3;
    ex_ir = ADD_RD3;
    #1;
    chk1("nostall_notload", stall, 1'b0);
  endtask

  task automatic test_flush();
    ex_ir = LOAD_R3;
    id_ir = ADD_RS1_3;
    branch_taken = 1'b1;
    #1;
    chk1("flush_set", flush, 1'b1);
    chk1("flush_beats_stall", stall, 1'b0);
    branch_taken = 1'b0;
    #1;
    chk1("flush_clear", flush, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    branch_taken = 1'b1;
    #1;
    chk1("idle_no_flush", flush, 1'b0);
    chk1("idle_no_stall2", stall, 1'b0);
    branch_taken = 1'b0;
  endtask

  task automatic test_halt();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk16("halt_pre_cnt", cycle_cnt, 16'd1);
    wb_ir = HALT_IR;
    stop  = 1'b1;
    tick();
    wb_ir = 16'h0;
    stop  = 1'b0;
    chk1("halted_flag", halted, 1'b1);
    chk1("halted_state", state, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk1("halted_ignore_step", halted, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk1("halted_ignore_stop", halted, 1'b1);
    chk16("halted_cnt_hold", cycle_cnt, 16'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("restart_state", state, 1'b1);
    chk1("restart_halted", halted, 1'b0);
    chk16("restart_cnt", cycle_cnt, 16'd0);
    tick();
    chk16("restart_cnt1", cycle_cnt, 16'd1);
  endtask

  task automatic test_saturate();
    int n = 0;
    while (cycle_cnt != 16'hFFFF && n < 70000) begin
      tick();
      n++;
    end
    chk16("sat_reached", cycle_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) tick();
    chk16("sat_hold", cycle_cnt, 16'hFFFF);
    chk1("sat_still_run", state, 1'b1);
    ex_ir = LOAD_R3;
    id_ir = ADD_RS1_3;
    #1;
    chk1("pre_reset_stall", stall, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("midrun_reset_state", state, 1'b0);
    chk16("midrun_reset_cnt", cycle_cnt, 16'h0);
    chk1("midrun_reset_stall", stall, 1'b0);
    chk1("midrun_reset_halted", halted, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk1("post_reset_idle", state, 1'b0);
    chk16("post_reset_cnt", cycle_cnt, 16'h0);
  endtask

  initial begin
    test_reset();
    test_start();
    test_step();
    test_stall();
    test_flush();
    test_halt();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
